exe_muldiv_sched: RTL

//  Sequences the shared iterative multiplier and divider for the execute stage. Accepts one M-extension op, fires a one-cycle start

---
 rtl/exe_muldiv_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/exe_muldiv_sched.sv
// Execute-stage sequencer for the shared iterative multiplier/divider: accepts one M-extension op,
// pulses the unit's start, waits for ready, and holds the result until the pipeline consumes it.
module exe_muldiv_sched #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              I_valid,
   input  logic [2:0]        I_op,
   input  logic [XLEN-1:0]   I_srca,
   input  logic [XLEN-1:0]   I_srcb,
   input  logic              I_flush,
   input  logic              I_stall_other,
   output logic              O_stallreq,
   output logic              O_result_valid,
   output logic [XLEN-1:0]   O_result,
   output logic              O_mul_start,
   output logic [XLEN-1:0]   O_mul_a,
   output logic [XLEN-1:0]   O_mul_b,
   output logic              O_mul_sa,
   output logic              O_mul_sb,
   input  logic              I_mul_ready,
   input  logic [2*XLEN-1:0] I_mul_product,
   output logic              O_div_start,
   output logic              O_div_signed,
   output logic [XLEN-1:0]   O_div_a,
   output logic [XLEN-1:0]   O_div_b,
   output logic              O_div_annul,
   input  logic              I_div_ready,
   input  logic [XLEN-1:0]   I_div_quot,
   input  logic [XLEN-1:0]   I_div_rem
);

   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE, S_MUL_WAIT, S_DIV_WAIT, S_MUL_DRAIN, S_HOLD
   } state_e;

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            mul_start_q, mul_start_d;
   logic            div_start_q, div_start_d;
   logic            annul;

   // Ready coinciding with the start pulse belongs to no op of ours.
   logic mul_rdy, div_rdy;
   assign mul_rdy = I_mul_ready & ~mul_start_q;
   assign div_rdy = I_div_ready & ~div_start_q;

   // Decode of the incoming op: bit 2 selects divider, bit 1 remainder, bit 0 unsigned.
   logic in_div, in_rem, in_signed;
   assign in_div    = I_op[2];
   assign in_rem    = I_op[1];
   assign in_signed = ~I_op[0];

   always_comb begin
      // NOTE: every variable gets a default first, so no path through the case can infer a latch.
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      mul_start_d = 1'b0;
      div_start_d = 1'b0;
      annul       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (I_valid && !I_flush) begin
               op_d = op_e'(I_op);
               a_d  = I_srca;
               b_d  = I_srcb;
               if (in_div && (I_srcb == '0)) begin
                  result_d = in_rem ? I_srca : '1;
                  state_d  = S_HOLD;
               end else if (in_div && in_signed && (I_srca == MIN_INT) && (I_srcb == '1)) begin
                  result_d = in_rem ? '0 : I_srca;
                  state_d  = S_HOLD;
               end else if (in_div) begin
                  div_start_d = 1'b1;
                  state_d     = S_DIV_WAIT;
               end else begin
                  mul_start_d = 1'b1;
                  state_d     = S_MUL_WAIT;
               end
            end
         end
         S_MUL_WAIT: begin
            if (I_flush) begin
               // A product landing in the flush cycle is already done; nothing left to drain.
               state_d = mul_rdy ? S_IDLE : S_MUL_DRAIN;
            end else if (mul_rdy) begin
               result_d = (op_q == OP_MUL) ? I_mul_product[XLEN-1:0] : I_mul_product[2*XLEN-1:XLEN];
               state_d  = S_HOLD;
            end
         end
         S_DIV_WAIT: begin
            if (I_flush) begin
               annul   = 1'b1;
               state_d = S_IDLE;
            end else if (div_rdy) begin
               result_d = op_q[1] ? I_div_rem : I_div_quot;
               state_d  = S_HOLD;
            end
         end
         S_MUL_DRAIN: begin
            if (I_mul_ready) state_d = S_IDLE;
         end
         S_HOLD: begin
            if (I_flush || !I_stall_other) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_MUL;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         mul_start_q <= 1'b0;
         div_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         mul_start_q <= mul_start_d;
         div_start_q <= div_start_d;
      end
   end

   assign O_stallreq     = I_valid & (state_q != S_HOLD) & ~I_flush;
   assign O_result_valid = (state_q == S_HOLD);
   assign O_result       = result_q;
   assign O_mul_start    = mul_start_q;
   assign O_mul_a        = a_q;
   assign O_mul_b        = b_q;
   assign O_mul_sa       = (op_q == OP_MULH) || (op_q == OP_MULHSU);
   assign O_mul_sb       = (op_q == OP_MULH);
   assign O_div_start    = div_start_q;
   assign O_div_signed   = op_q[2] & ~op_q[0];
   assign O_div_a        = a_q;
   assign O_div_b        = b_q;
   assign O_div_annul    = annul;

endmodule
